// File: rtl/fifo_ptr_ctrl_if.sv
// Pointer-controller handshake bundle: local inc request, remote Gray pointer in,
// address/pointer/status out.
interface fifo_ptr_ctrl_if #(
    parameter int unsigned ADDR_W = 3
);
    logic              inc;
    logic [ADDR_W:0]   remote_ptr;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W:0]   ptr;
    logic              flag;
    logic              almost;
    logic [ADDR_W:0]   level;
    logic              err;

    modport master (
        output inc, remote_ptr,
        input  addr, ptr, flag, almost, level, err
    );

    modport slave (
        input  inc, remote_ptr,
        output addr, ptr, flag, almost, level, err
    );
endinterface

// File: rtl/fifo_ptr_ctrl.sv
// One side of a dual-clock FIFO: binary/Gray pointer, remote pointer synchroniser,
// and registered full/empty, almost, level and sticky error.
module fifo_ptr_ctrl #(
    parameter int unsigned ADDR_W      = 3,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned MODE        = 0,
    parameter int unsigned ALMOST_TH   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    fifo_ptr_ctrl_if.slave        bus
);
    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] HI_TH = (ADDR_W+1)'(DEPTH - ALMOST_TH);
    localparam logic [ADDR_W:0] LO_TH = (ADDR_W+1)'(ALMOST_TH);

    logic [ADDR_W:0] bin_q, ptr_q, level_q;
    logic            flag_q, almost_q, err_q;
    logic [ADDR_W:0] sync_q [SYNC_STAGES];

    logic            accept;
    logic [ADDR_W:0] bin_next, gray_next, rsync, rbin, level_next, full_cmp;
    logic            flag_next, almost_next;

    assign accept    = bus.inc & ~flag_q;
    assign bin_next  = bin_q + {{ADDR_W{1'b0}}, accept};
    assign gray_next = bin_next ^ (bin_next >> 1);
    assign rsync     = sync_q[SYNC_STAGES-1];
    // Full when the local pointer is exactly one lap ahead: top two Gray bits inverted.
    assign full_cmp  = {~rsync[ADDR_W:ADDR_W-1], rsync[ADDR_W-2:0]};

    always_comb begin
        rbin         = '0;
        rbin[ADDR_W] = rsync[ADDR_W];
        for (int i = ADDR_W - 1; i >= 0; i--) begin
            rbin[i] = rbin[i+1] ^ rsync[i];
        end
    end

    always_comb begin
        flag_next   = 1'b0;
        level_next  = '0;
        almost_next = 1'b0;
        if (MODE == 0) begin
            flag_next   = (gray_next == full_cmp);
            level_next  = bin_next - rbin;
            almost_next = (level_next >= HI_TH);
        end else begin
            flag_next   = (gray_next == rsync);
            level_next  = rbin - bin_next;
            almost_next = (level_next <= LO_TH);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= bus.remote_ptr;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bin_q    <= '0;
            ptr_q    <= '0;
            level_q  <= '0;
            flag_q   <= (MODE != 0);
            almost_q <= (MODE != 0);
            err_q    <= 1'b0;
        end else begin
            bin_q    <= bin_next;
            ptr_q    <= gray_next;
            level_q  <= level_next;
            flag_q   <= flag_next;
            almost_q <= almost_next;
            err_q    <= err_q | (bus.inc & flag_q);
        end
    end

    assign bus.addr   = bin_q[ADDR_W-1:0];
    assign bus.ptr    = ptr_q;
    assign bus.flag   = flag_q;
    assign bus.almost = almost_q;
    assign bus.level  = level_q;
    assign bus.err    = err_q;
endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
// Directed bench for fifo_ptr_ctrl: one write-side and one read-side instance.
module tb_fifo_ptr_ctrl;
    logic clk = 1'b0;
    logic rst_wr = 1'b1;
    logic rst_rd = 1'b1;
    int   n_checks = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    fifo_ptr_ctrl_if #(.ADDR_W(3)) wr_if ();
    fifo_ptr_ctrl_if #(.ADDR_W(3)) rd_if ();

    fifo_ptr_ctrl #(.ADDR_W(3), .SYNC_STAGES(2), .MODE(0), .ALMOST_TH(1)) u_wr (
        .clk (clk),
        .rst (rst_wr),
        .bus (wr_if.slave)
    );

    fifo_ptr_ctrl #(.ADDR_W(3), .SYNC_STAGES(2), .MODE(1), .ALMOST_TH(1)) u_rd (
        .clk (clk),
        .rst (rst_rd),
        .bus (rd_if.slave)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Advance one edge; outputs are sampled and inputs changed 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_wr(input string tag, input logic [2:0] addr, input logic [3:0] ptr,
                            input logic flag, input logic almost, input logic [3:0] level,
                            input logic err);
        check({tag, ".addr"}, 32'(wr_if.addr), 32'(addr));
        check({tag, ".ptr"}, 32'(wr_if.ptr), 32'(ptr));
        check({tag, ".flag"}, 32'(wr_if.flag), 32'(flag));
        check({tag, ".almost"}, 32'(wr_if.almost), 32'(almost));
        check({tag, ".level"}, 32'(wr_if.level), 32'(level));
        check({tag, ".err"}, 32'(wr_if.err), 32'(err));
    endtask

    task automatic check_rd(input string tag, input logic [2:0] addr, input logic [3:0] ptr,
                            input logic flag, input logic almost, input logic [3:0] level,
                            input logic err);
        check({tag, ".addr"}, 32'(rd_if.addr), 32'(addr));
        check({tag, ".ptr"}, 32'(rd_if.ptr), 32'(ptr));
        check({tag, ".flag"}, 32'(rd_if.flag), 32'(flag));
        check({tag, ".almost"}, 32'(rd_if.almost), 32'(almost));
        check({tag, ".level"}, 32'(rd_if.level), 32'(level));
        check({tag, ".err"}, 32'(rd_if.err), 32'(err));
    endtask

    logic [3:0] ptr_seq [9];
    logic [3:0] rd_ptr_seq [9];

    initial begin
        ptr_seq = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC};
        rd_ptr_seq = '{4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};
        wr_if.inc = 1'b0;
        wr_if.remote_ptr = '0;
        rd_if.inc = 1'b1;  // reset must win over inc
        rd_if.remote_ptr = '0;
        wr_if.inc = 1'b1;
        step();
        step();
        wr_if.inc = 1'b0;
        rd_if.inc = 1'b0;

        // Reset values of both sides
        check_wr("rst_wr", 3'd0, 4'h0, 1'b0, 1'b0, 4'd0, 1'b0);
        check_rd("rst_rd", 3'd0, 4'h0, 1'b1, 1'b1, 4'd0, 1'b0);
        rst_wr = 1'b0;
        rst_rd = 1'b0;

        // Write side fills with remote at zero; ninth push is rejected
        wr_if.inc = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            step();
            check_wr($sformatf("fill%0d", i), 3'(i % 8), ptr_seq[i], (i == 8), (i >= 7),
                     4'(i), 1'b0);
        end
        step();
        check_wr("fill9_rej", 3'd0, 4'hC, 1'b1, 1'b1, 4'd8, 1'b1);
        wr_if.inc = 1'b0;

        // Remote read pointer advances by one; full drops after two synchroniser edges
        wr_if.remote_ptr = 4'h1;
        step();
        step();
        check("wr_sync_hold.flag", 32'(wr_if.flag), 32'd1);
        step();
        check_wr("wr_free1", 3'd0, 4'hC, 1'b0, 1'b1, 4'd7, 1'b1);

        // Refill to full, then reset with inc high
        wr_if.inc = 1'b1;
        step();
        check_wr("wr_refill", 3'd1, 4'hD, 1'b1, 1'b1, 4'd8, 1'b1);
        rst_wr = 1'b1;
        step();
        check_wr("wr_midrst", 3'd0, 4'h0, 1'b0, 1'b0, 4'd0, 1'b0);
        rst_wr = 1'b0;
        wr_if.inc = 1'b0;
        wr_if.remote_ptr = 4'h0;
        step();
        check_wr("wr_postrst", 3'd0, 4'h0, 1'b0, 1'b0, 4'd0, 1'b0);

        // Read side: remote shows 8 written entries
        rd_if.remote_ptr = 4'hC;
        step();
        step();
        check("rd_sync_hold.flag", 32'(rd_if.flag), 32'd1);
        step();
        check_rd("rd_avail8", 3'd0, 4'h0, 1'b0, 1'b0, 4'd8, 1'b0);
        rd_if.inc = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            step();
            check_rd($sformatf("pop%0d", i), 3'(i % 8), ptr_seq[i], (i == 8), (i >= 7),
                     4'(8 - i), 1'b0);
        end
        rd_if.inc = 1'b0;

        // Remote wraps to count 16 (Gray 0)
        rd_if.remote_ptr = 4'h0;
        step();
        step();
        step();
        check_rd("rd_wrap8", 3'd0, 4'hC, 1'b0, 1'b0, 4'd8, 1'b0);
        rd_if.inc = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            step();
            check(
                $sformatf("pop2_%0d.ptr", i), 32'(rd_if.ptr), 32'(rd_ptr_seq[i]));
            check($sformatf("pop2_%0d.level", i), 32'(rd_if.level), 32'(8 - i));
        end
        rd_if.inc = 1'b0;
        check_rd("rd_empty2", 3'd0, 4'h0, 1'b1, 1'b1, 4'd0, 1'b0);

        // Pop while remote moves on the same cycle: transient empty
        rst_rd = 1'b1;
        step();
        rst_rd = 1'b0;
        rd_if.remote_ptr = 4'h1;
        step();
        step();
        step();
        check_rd("rd_lvl1", 3'd0, 4'h0, 1'b0, 1'b1, 4'd1, 1'b0);
        rd_if.inc = 1'b1;
        rd_if.remote_ptr = 4'h3;
        step();
        rd_if.inc = 1'b0;
        check_rd("rd_transient", 3'd1, 4'h1, 1'b1, 1'b1, 4'd0, 1'b0);
        step();
        check("rd_trans_hold.flag", 32'(rd_if.flag), 32'd1);
        step();
        check_rd("rd_recover", 3'd1, 4'h1, 1'b0, 1'b1, 4'd1, 1'b0);

        // Underflow attempt sets err, reset clears it
        rd_if.remote_ptr = 4'h1;
        step();
        step();
        step();
        rd_if.inc = 1'b1;
        step();
        check("rd_underflow.err", 32'(rd_if.err), 32'd1);
        check("rd_underflow.ptr", 32'(rd_if.ptr), 32'h1);
        rst_rd = 1'b1;
        step();
        check_rd("rd_midrst", 3'd0, 4'h0, 1'b1, 1'b1, 4'd0, 1'b0);
        rst_rd = 1'b0;
        rd_if.inc = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
